seg7_scan_n: RTL and testbench

//  Time-multiplexed driver for an N-digit common-anode/cathode 7-seg+DP display.

---
 rtl/seg7_pkg.sv | 33 +++
 rtl/seg7_scan_timer.sv | 69 ++++++
 rtl/seg7_scan_n.sv | 110 +++++++++++
 tb/tb_seg7_scan_n.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment driver: blank pattern, glyphs
// (active-low segments, bit 7 = DP) and the anode one-hot helper.
package seg7_pkg;

  localparam logic [7:0] SEG_OFF_DEFAULT = 8'hFF;

  localparam logic [7:0] GLYPH_0     = 8'hC0;
  localparam logic [7:0] GLYPH_1     = 8'hF9;
  localparam logic [7:0] GLYPH_2     = 8'hA4;
  localparam logic [7:0] GLYPH_3     = 8'hB0;
  localparam logic [7:0] GLYPH_4     = 8'h99;
  localparam logic [7:0] GLYPH_5     = 8'h92;
  localparam logic [7:0] GLYPH_6     = 8'h82;
  localparam logic [7:0] GLYPH_7     = 8'hF8;
  localparam logic [7:0] GLYPH_8     = 8'h80;
  localparam logic [7:0] GLYPH_9     = 8'h90;
  localparam logic [7:0] GLYPH_A     = 8'h88;
  localparam logic [7:0] GLYPH_B     = 8'h83;
  localparam logic [7:0] GLYPH_C     = 8'hC6;
  localparam logic [7:0] GLYPH_D     = 8'hA1;
  localparam logic [7:0] GLYPH_E     = 8'h86;
  localparam logic [7:0] GLYPH_F     = 8'h8E;
  localparam logic [7:0] GLYPH_BLANK = 8'hFF;
  localparam logic [7:0] GLYPH_DASH  = 8'hBF;

  // Up to 8 digits; the caller truncates to its own digit count.
  function automatic logic [7:0] onehot_an(input logic [2:0] pos, input logic active_high);
    logic [7:0] v;
    v = 8'd1 << pos;
    return active_high ? v : ~v;
  endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Scan timing for the multiplexed display: slot counter, digit position,
// PWM phase, blink phase and the frame-end strobe.
module seg7_scan_timer #(
  parameter int N_DIGITS     = 4,
  parameter int SCAN_CNT     = 625000,
  parameter int BLANK_CNT    = 1000,
  parameter int BLINK_FRAMES = 32,
  parameter int POS_W        = $clog2(N_DIGITS)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  output logic [POS_W-1:0] o_pos,
  output logic [3:0]       o_pwm_cnt,
  output logic             o_blank,
  output logic             o_blink_off,
  output logic             o_frame_end
);
  localparam int SLOT_W = $clog2(SCAN_CNT);
  localparam int FC_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_CNT - 1);
  localparam logic [SLOT_W-1:0] BLANK_END = SLOT_W'(BLANK_CNT);
  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(N_DIGITS - 1);
  localparam logic [FC_W-1:0]   FC_LAST   = FC_W'(BLINK_FRAMES - 1);

  logic [SLOT_W-1:0] r_slot_cnt;
  logic [POS_W-1:0]  r_pos;
  logic [3:0]        r_pwm_cnt;
  logic [FC_W-1:0]   r_frame_cnt;
  logic              r_blink_off;
  logic              w_slot_last;
  logic              w_frame_end;

  assign w_slot_last = (r_slot_cnt == SLOT_LAST);
  assign w_frame_end = w_slot_last && (r_pos == POS_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_slot_cnt  <= '0;
      r_pos       <= '0;
      r_pwm_cnt   <= '0;
      r_frame_cnt <= '0;
      r_blink_off <= 1'b0;
    end else begin
      // PWM restarts with every slot so each digit gets the same duty pattern.
      r_pwm_cnt <= w_slot_last ? 4'd0 : r_pwm_cnt + 4'd1;
      if (w_slot_last) begin
        r_slot_cnt <= '0;
        r_pos      <= (r_pos == POS_LAST) ? '0 : r_pos + POS_W'(1);
      end else begin
        r_slot_cnt <= r_slot_cnt + SLOT_W'(1);
      end
      if (w_frame_end) begin
        if (r_frame_cnt == FC_LAST) begin
          r_frame_cnt <= '0;
          r_blink_off <= ~r_blink_off;
        end else begin
          r_frame_cnt <= r_frame_cnt + FC_W'(1);
        end
      end
    end
  end

  assign o_pos       = r_pos;
  assign o_pwm_cnt   = r_pwm_cnt;
  assign o_blank     = (r_slot_cnt < BLANK_END);
  assign o_blink_off = r_blink_off;
  assign o_frame_end = w_frame_end;

endmodule

// File: rtl/seg7_scan_n.sv
// N-digit multiplexed 7-seg driver with dead-time, double-buffered codes,
// per-digit enable/blink and 16-level PWM brightness.
module seg7_scan_n
  import seg7_pkg::*;
#(
  parameter int         N_DIGITS       = 4,
  parameter int         SCAN_CNT       = 625000,
  parameter int         BLANK_CNT      = 1000,
  parameter int         BLINK_FRAMES   = 32,
  parameter int         AN_ACTIVE_HIGH = 1,
  parameter logic [7:0] SEG_OFF        = SEG_OFF_DEFAULT
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [8*N_DIGITS-1:0] i_codes,
  input  logic                  i_load,
  input  logic [N_DIGITS-1:0]   i_digit_en,
  input  logic [N_DIGITS-1:0]   i_blink_en,
  input  logic [3:0]            i_bright,
  output logic [N_DIGITS-1:0]   o_an,
  output logic [7:0]            o_seg_code,
  output logic                  o_frame_tick
);
  localparam int POS_W = $clog2(N_DIGITS);
  localparam logic [N_DIGITS-1:0] AN_OFF = (AN_ACTIVE_HIGH != 0) ? '0 : '1;

  logic [POS_W-1:0]      w_pos;
  logic [3:0]            w_pwm_cnt;
  logic                  w_blank;
  logic                  w_blink_off;
  logic                  w_frame_end;
  logic [8*N_DIGITS-1:0] w_active_flat;
  logic                  w_lit;
  logic                  r_pending_vld;
  logic [N_DIGITS-1:0]   r_an;
  logic [7:0]            r_seg_code;

  seg7_scan_timer #(
    .N_DIGITS     (N_DIGITS),
    .SCAN_CNT     (SCAN_CNT),
    .BLANK_CNT    (BLANK_CNT),
    .BLINK_FRAMES (BLINK_FRAMES),
    .POS_W        (POS_W)
  ) u_timer (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .o_pos        (w_pos),
    .o_pwm_cnt    (w_pwm_cnt),
    .o_blank      (w_blank),
    .o_blink_off  (w_blink_off),
    .o_frame_end  (w_frame_end)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending_vld <= 1'b0;
    end else if (w_frame_end) begin
      r_pending_vld <= 1'b0;
    end else if (i_load) begin
      r_pending_vld <= 1'b1;
    end
  end

  // Codes only reach the displayed buffer at a frame boundary, so a frame never mixes old and new.
  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
    logic [7:0] r_pending;
    logic [7:0] r_active;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_pending <= SEG_OFF;
        r_active  <= SEG_OFF;
      end else begin
        if (i_load && !w_frame_end) begin
          r_pending <= i_codes[8*gi +: 8];
        end
        if (w_frame_end && i_load) begin
          r_active <= i_codes[8*gi +: 8];
        end else if (w_frame_end && r_pending_vld) begin
          r_active <= r_pending;
        end
      end
    end

    assign w_active_flat[8*gi +: 8] = r_active;
  end

  assign w_lit = i_digit_en[w_pos]
              && !(i_blink_en[w_pos] && w_blink_off)
              && !w_blank
              && (w_pwm_cnt <= i_bright);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_an       <= AN_OFF;
      r_seg_code <= SEG_OFF;
    end else if (w_lit) begin
      r_an       <= N_DIGITS'(onehot_an(3'(w_pos), AN_ACTIVE_HIGH != 0));
      r_seg_code <= w_active_flat[{w_pos, 3'b000} +: 8];
    end else begin
      r_an       <= AN_OFF;
      r_seg_code <= SEG_OFF;
    end
  end

  assign o_an         = r_an;
  assign o_seg_code   = r_seg_code;
  assign o_frame_tick = w_frame_end;

endmodule

// File: tb/tb_seg7_scan_n.sv
// Scoreboard bench for seg7_scan_n (3 digits, 20-cycle slots, 2 blank cycles, blink every 2 frames).
module tb_seg7_scan_n;
  localparam int N      = 3;
  localparam int SCAN   = 20;
  localparam int BLANK  = 2;
  localparam int BLINKF = 2;
  localparam int FRAME  = N * SCAN;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] codes = '0;
  logic        load = 1'b0;
  logic [2:0]  den = '0;
  logic [2:0]  ben = '0;
  logic [3:0]  bright = '0;
  logic [2:0]  an;
  logic [7:0]  seg;
  logic        ft;

  always #5 clk = ~clk;

  seg7_scan_n #(
    .N_DIGITS       (N),
    .SCAN_CNT       (SCAN),
    .BLANK_CNT      (BLANK),
    .BLINK_FRAMES   (BLINKF),
    .AN_ACTIVE_HIGH (1),
    .SEG_OFF        (8'hFF)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_codes      (codes),
    .i_load       (load),
    .i_digit_en   (den),
    .i_blink_en   (ben),
    .i_bright     (bright),
    .o_an         (an),
    .o_seg_code   (seg),
    .o_frame_tick (ft)
  );

  typedef struct packed {
    logic [2:0] an;
    logic [7:0] seg;
    logic       ft;
    int         t;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;

  // Reference model: time since reset release plus the displayed/pending code sets.
  int         t;
  logic [7:0] m_active[N];
  logic [7:0] m_pending[N];
  bit         m_vld;

  always @(posedge clk) begin
    #1;
    if (rst_n && sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      checks++;
      if (an !== mon_e.an || seg !== mon_e.seg || ft !== mon_e.ft) begin
        errors++;
        $display("FAIL scan_out t=%0d actual an=%b seg=%h tick=%b required an=%b seg=%h tick=%b",
                 mon_e.t, an, seg, ft, mon_e.an, mon_e.seg, mon_e.ft);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic model_reset();
    t = 0;
    m_vld = 1'b0;
    for (int k = 0; k < N; k++) begin
      m_active[k]  = 8'hFF;
      m_pending[k] = 8'hFF;
    end
  endtask

  // Called at a falling edge with the DUT in model state t.
  task automatic step(input bit ld);
    int   slot, pos, pwm, frame;
    bit   boff, fend, lit;
    exp_t e;
    slot  = t % SCAN;
    pos   = (t / SCAN) % N;
    pwm   = slot % 16;
    frame = t / FRAME;
    boff  = ((frame / BLINKF) % 2) == 1;
    fend  = (t % FRAME) == FRAME - 1;
    load  = ld;
    lit   = den[pos] && !(ben[pos] && boff) && (slot >= BLANK) && (pwm <= int'(bright));
    e.an  = lit ? 3'(1 << pos) : 3'b000;
    e.seg = lit ? m_active[pos] : 8'hFF;
    e.ft  = ((t + 1) % FRAME) == FRAME - 1;
    e.t   = t;
    sb_q.push_back(e);
    if (ld) $display("load t=%0d digit=%0d slot=%0d codes=%h frame_end=%0d", t, pos, slot, codes, fend);
    if (ld && fend) begin
      for (int k = 0; k < N; k++) m_active[k] = codes[8*k +: 8];
      m_vld = 1'b0;
    end else if (fend && m_vld) begin
      for (int k = 0; k < N; k++) m_active[k] = m_pending[k];
      m_vld = 1'b0;
    end else if (ld) begin
      for (int k = 0; k < N; k++) m_pending[k] = codes[8*k +: 8];
      m_vld = 1'b1;
    end
    t++;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    int w;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_an", 32'(an), 32'h0);
    chk("reset_seg", 32'(seg), 32'hFF);
    chk("reset_tick", 32'(ft), 32'h0);

    // Basic scan: codes captured at t=0 become visible after the first frame end.
    codes  = {8'hA4, 8'hF9, 8'hC0};
    den    = 3'b111;
    ben    = 3'b000;
    bright = 4'd15;
    rst_n  = 1'b1;
    step(1'b1);
    repeat (4 * FRAME) step(1'b0);

    // Mid-frame load while digit 1 is scanning.
    while ((t % FRAME) != SCAN + 10) step(1'b0);
    codes = {8'hB0, 8'h99, 8'h92};
    step(1'b1);
    repeat (2 * FRAME) step(1'b0);

    // Load on the frame-end cycle.
    while ((t % FRAME) != FRAME - 1) step(1'b0);
    codes = {8'h82, 8'hF8, 8'h80};
    step(1'b1);
    repeat (FRAME) step(1'b0);

    // Digit masking and blink.
    den = 3'b101;
    ben = 3'b001;
    repeat (8 * FRAME) step(1'b0);

    // Brightness.
    den    = 3'b111;
    ben    = 3'b000;
    bright = 4'd3;
    repeat (FRAME) step(1'b0);
    bright = 4'd0;
    repeat (FRAME) step(1'b0);

    // Randomised mix of loads, masks and brightness.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        den    = 3'($urandom);
        ben    = 3'($urandom);
        bright = 4'($urandom);
      end
      codes = 24'($urandom);
      step($urandom_range(0, 24) == 0);
    end

    // Asynchronous reset in the middle of a lit slot.
    den    = 3'b111;
    ben    = 3'b000;
    bright = 4'd15;
    while ((t % SCAN) != 9) step(1'b0);
    chk("pre_reset_lit", 32'(an), 32'(1 << ((t - 1) / SCAN % N)));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_an", 32'(an), 32'h0);
    chk("async_seg", 32'(seg), 32'hFF);
    chk("async_tick", 32'(ft), 32'h0);
    repeat (3) @(negedge clk);
    chk("hold_an", 32'(an), 32'h0);
    chk("hold_seg", 32'(seg), 32'hFF);
    model_reset();
    rst_n = 1'b1;
    repeat (2 * FRAME) step(1'b0);
    codes = {8'h8E, 8'h86, 8'hA1};
    step(1'b1);
    repeat (2 * FRAME) step(1'b0);

    w = 0;
    while (sb_q.size() > 0 && w < 5) begin
      @(posedge clk);
      #2;
      w++;
    end
    chk("scoreboard_drain", 32'(sb_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
